// File: rtl/guide_pkg.sv
// Shared types and guide-box geometry for the guide region detector.
// Box edges are exclusive: a pixel on any edge value lies outside the interior.
package guide_pkg;

   typedef enum logic [1:0] {
      GUIDE_NONE   = 2'b00,
      GUIDE_BOTTOM = 2'b01,
      GUIDE_TOP    = 2'b10
   } guide_sel_e;

   localparam logic [10:0] L_X0   = 11'd20;
   localparam logic [10:0] L_X1   = 11'd460;
   localparam logic [10:0] R_X0   = 11'd1460;
   localparam logic [10:0] R_X1   = 11'd1900;
   localparam logic [10:0] TOP_Y0 = 11'd20;
   localparam logic [10:0] MID_Y  = 11'd380;
   localparam logic [10:0] BOT_Y1 = 11'd700;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_EVAL,
      ST_REPORT
   } state_e;

endpackage

// File: rtl/guide_region_counter.sv
// One guide-box interior counter: strict-inequality region test, synchronous
// clear and a counter that sticks at its all-ones value.
module guide_region_counter #(
   parameter int CNT_W = 18
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             region_en_i,
   input  logic             de_i,
   input  logic             match_i,
   input  logic [10:0]      x_i,
   input  logic [10:0]      y_i,
   input  logic [10:0]      x_lo_i,
   input  logic [10:0]      x_hi_i,
   input  logic [10:0]      y_lo_i,
   input  logic [10:0]      y_hi_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             in_region;
   logic             cnt_full;

   assign in_region = region_en_i && (x_i > x_lo_i) && (x_i < x_hi_i)
                      && (y_i > y_lo_i) && (y_i < y_hi_i);
   assign cnt_full  = &cnt_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && de_i && match_i && in_region && !cnt_full) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/guide_region_detector.sv
// Per-frame guide-box hit detector: counts mask pixels inside the active boxes
// and reports per-box hits after each frame. GUIDE_DEBOUNCE_EN adds a streak filter.
module guide_region_detector
   import guide_pkg::*;
#(
   parameter int CNT_W       = 18,
   parameter int THRESH      = 20000,
   parameter int HOLD_FRAMES = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       sel,
   input  logic [10:0]      x,
   input  logic [10:0]      y,
   input  logic             de,
   input  logic             vsync,
   input  logic             pixel_match,
   output logic [CNT_W-1:0] count0,
   output logic [CNT_W-1:0] count1,
   output logic             hit0,
   output logic             hit1,
   output logic [1:0]       active_sel,
   output logic             result_valid
);

   state_e           state_q, state_d;
   logic             vsync_d;
   logic [1:0]       mode_q;
   logic             vs_fall, vs_rise, clr, acc;
   logic [CNT_W-1:0] count_q [2];
   logic             hit_q   [2];
   logic [1:0]       active_sel_q;

   logic [10:0]      x_lo [2];
   logic [10:0]      x_hi [2];
   logic [10:0]      y_lo [2];
   logic [10:0]      y_hi [2];
   logic             region_en [2];
   logic [CNT_W-1:0] cnt  [2];
   logic             pass [2];
   logic             hit_d [2];

   assign vs_fall = vsync_d && !vsync;
   assign vs_rise = !vsync_d && vsync;
   assign clr     = (state_q == ST_IDLE) && vs_fall;
   assign acc     = (state_q == ST_ACCUM);

   // Region 0 is the left box; its rows depend on whether it is the bottom or top box.
   always_comb begin
      region_en[0] = (mode_q == GUIDE_BOTTOM) || (mode_q == GUIDE_TOP);
      region_en[1] = (mode_q == GUIDE_TOP);
      x_lo[0]      = L_X0;
      x_hi[0]      = L_X1;
      y_lo[0]      = (mode_q == GUIDE_BOTTOM) ? MID_Y  : TOP_Y0;
      y_hi[0]      = (mode_q == GUIDE_BOTTOM) ? BOT_Y1 : MID_Y;
      x_lo[1]      = R_X0;
      x_hi[1]      = R_X1;
      y_lo[1]      = TOP_Y0;
      y_hi[1]      = MID_Y;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_region
         guide_region_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .reset_n     (reset_n),
            .clr_i       (clr),
            .en_i        (acc),
            .region_en_i (region_en[gi]),
            .de_i        (de),
            .match_i     (pixel_match),
            .x_i         (x),
            .y_i         (y),
            .x_lo_i      (x_lo[gi]),
            .x_hi_i      (x_hi[gi]),
            .y_lo_i      (y_lo[gi]),
            .y_hi_i      (y_hi[gi]),
            .count_o     (cnt[gi])
         );
         assign pass[gi] = region_en[gi] && (cnt[gi] >= CNT_W'(THRESH));
      end
   endgenerate

`ifdef GUIDE_DEBOUNCE_EN
   localparam int SW = $clog2(HOLD_FRAMES + 1);
   logic [SW-1:0] streak_q [2];
   logic [SW-1:0] streak_d [2];
   logic [1:0]    prev_mode_q;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         streak_d[i] = streak_q[i];
         if (pass[i] && (mode_q == prev_mode_q)) begin
            if (streak_q[i] != SW'(HOLD_FRAMES)) streak_d[i] = streak_q[i] + 1'b1;
         end else begin
            streak_d[i] = pass[i] ? SW'(1) : SW'(0);
         end
         hit_d[i] = (streak_d[i] == SW'(HOLD_FRAMES));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_mode_q <= 2'b00;
         streak_q[0] <= '0;
         streak_q[1] <= '0;
      end else if (state_q == ST_EVAL) begin
         prev_mode_q <= mode_q;
         streak_q[0] <= streak_d[0];
         streak_q[1] <= streak_d[1];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < 2; i++) hit_d[i] = pass[i];
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (vs_fall) state_d = ST_ACCUM;
         ST_ACCUM:  if (vs_rise) state_d = ST_EVAL;
         ST_EVAL:   state_d = ST_REPORT;
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         vsync_d      <= 1'b0;
         mode_q       <= 2'b00;
         count_q[0]   <= '0;
         count_q[1]   <= '0;
         hit_q[0]     <= 1'b0;
         hit_q[1]     <= 1'b0;
         active_sel_q <= 2'b00;
      end else begin
         state_q <= state_d;
         vsync_d <= vsync;
         if (clr) mode_q <= sel;
         if (state_q == ST_EVAL) begin
            for (int i = 0; i < 2; i++) begin
               count_q[i] <= region_en[i] ? cnt[i] : '0;
               hit_q[i]   <= hit_d[i];
            end
            active_sel_q <= mode_q;
         end
      end
   end

   assign count0       = count_q[0];
   assign count1       = count_q[1];
   assign hit0         = hit_q[0];
   assign hit1         = hit_q[1];
   assign active_sel   = active_sel_q;
   assign result_valid = (state_q == ST_REPORT);

endmodule
